// File: rtl/tlul_socket_1n_ordered.sv
// TL-UL 1:N steering socket with strictly ordered responses.
// Includes the minimal tlul_pkg used by the socket and its bench.

package tlul_pkg;

  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    Get            = 3'h4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_op_e;

  typedef struct packed {
    logic        a_valid;
    tl_a_op_e    a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    tl_d_op_e    d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;

endpackage

module tlul_socket_1n_ordered #(
  parameter  int unsigned N              = 4,
  parameter  int unsigned MaxOutstanding = 8,
  localparam int unsigned NWD            = $clog2(N + 1)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  tlul_pkg::tl_h2d_t  tl_h_i,
  output tlul_pkg::tl_d2h_t  tl_h_o,
  input  logic [NWD-1:0]     dev_select_i,
  output tlul_pkg::tl_h2d_t  tl_d_o [N],
  input  tlul_pkg::tl_d2h_t  tl_d_i [N]
);
  import tlul_pkg::*;

  localparam int unsigned    CW     = $clog2(MaxOutstanding + 1);
  localparam logic [NWD-1:0] ErrIdx = NWD'(N);
  localparam logic [CW-1:0]  MaxCnt = CW'(MaxOutstanding);

  logic [CW-1:0]  out_cnt_q, out_cnt_d;
  logic [NWD-1:0] cur_dev_q, cur_dev_d;
  logic           err_pend_q, err_pend_d;
  logic [7:0]     err_source_q, err_source_d;
  logic [1:0]     err_size_q, err_size_d;
  logic           err_isget_q, err_isget_d;

  logic [NWD-1:0] tgt;
  logic           busy;
  logic           hold;
  logic           tgt_a_ready;
  logic           a_ready_w;
  logic           d_valid_w;
  logic           a_hs;
  logic           d_hs;
  tl_d2h_t        err_rsp;
  tl_d2h_t        sel_rsp;

  // Resolve target, decide whether the request must wait, pick target a_ready
  always_comb begin
    tgt         = (dev_select_i < ErrIdx) ? dev_select_i : ErrIdx;
    busy        = (out_cnt_q != '0);
    hold        = (busy && (tgt != cur_dev_q)) || (out_cnt_q == MaxCnt);
    tgt_a_ready = !err_pend_q;
    for (int unsigned j = 0; j < N; j++) begin
      if (tgt == NWD'(j)) tgt_a_ready = tl_d_i[j].a_ready;
    end
  end

  // Error responder response, presented the cycle after it accepts
  always_comb begin
    err_rsp          = '0;
    err_rsp.d_valid  = err_pend_q;
    err_rsp.d_opcode = err_isget_q ? AccessAckData : AccessAck;
    err_rsp.d_size   = err_size_q;
    err_rsp.d_source = err_source_q;
    err_rsp.d_data   = '1;
    err_rsp.d_error  = 1'b1;
  end

  // D-channel mux: only the device owning the outstanding requests is visible
  always_comb begin
    sel_rsp = err_rsp;
    for (int unsigned j = 0; j < N; j++) begin
      if (cur_dev_q == NWD'(j)) sel_rsp = tl_d_i[j];
    end
  end

  // Host-facing handshake signals
  always_comb begin
    a_ready_w = !hold && tgt_a_ready;
    d_valid_w = busy && sel_rsp.d_valid;
    a_hs      = tl_h_i.a_valid && a_ready_w;
    d_hs      = d_valid_w && tl_h_i.d_ready;
  end

  // Host response port
  always_comb begin
    tl_h_o         = sel_rsp;
    tl_h_o.d_valid = d_valid_w;
    tl_h_o.a_ready = a_ready_w;
  end

  // Device request ports: A fields broadcast, valid/ready steered
  always_comb begin
    for (int unsigned j = 0; j < N; j++) begin
      tl_d_o[j]         = tl_h_i;
      tl_d_o[j].a_valid = tl_h_i.a_valid && (tgt == NWD'(j)) && !hold;
      tl_d_o[j].d_ready = tl_h_i.d_ready && busy && (cur_dev_q == NWD'(j));
    end
  end

  // Next-state: outstanding count, current owner, error responder capture
  always_comb begin
    out_cnt_d    = out_cnt_q;
    cur_dev_d    = cur_dev_q;
    err_pend_d   = err_pend_q;
    err_source_d = err_source_q;
    err_size_d   = err_size_q;
    err_isget_d  = err_isget_q;

    if (a_hs) cur_dev_d = tgt;

    if (a_hs && !d_hs) begin
      out_cnt_d = out_cnt_q + CW'(1);
    end else if (!a_hs && d_hs) begin
      out_cnt_d = out_cnt_q - CW'(1);
    end

    // Capture and release cannot coincide: capture needs !err_pend, release needs err_pend
    if (a_hs && (tgt == ErrIdx)) begin
      err_pend_d   = 1'b1;
      err_source_d = tl_h_i.a_source;
      err_size_d   = tl_h_i.a_size;
      err_isget_d  = (tl_h_i.a_opcode == Get);
    end else if (d_hs && (cur_dev_q == ErrIdx)) begin
      err_pend_d = 1'b0;
    end
  end

  // State registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_cnt_q    <= '0;
      cur_dev_q    <= '0;
      err_pend_q   <= 1'b0;
      err_source_q <= '0;
      err_size_q   <= '0;
      err_isget_q  <= 1'b0;
    end else begin
      out_cnt_q    <= out_cnt_d;
      cur_dev_q    <= cur_dev_d;
      err_pend_q   <= err_pend_d;
      err_source_q <= err_source_d;
      err_size_q   <= err_size_d;
      err_isget_q  <= err_isget_d;
    end
  end

endmodule

// File: tb/tb_tlul_socket_1n_ordered.sv
// Randomized scoreboard bench for tlul_socket_1n_ordered.
module tb_tlul_socket_1n_ordered;
  import tlul_pkg::*;

  localparam int unsigned N   = 4;
  localparam int unsigned MO  = 4;
  localparam int unsigned NWD = $clog2(N + 1);

  logic           clk = 1'b0;
  logic           rst;
  tl_h2d_t        tl_h_i;
  tl_d2h_t        tl_h_o;
  logic [NWD-1:0] dev_sel;
  tl_h2d_t        tl_d_o [N];
  tl_d2h_t        tl_d_i [N];

  always #5 clk = ~clk;

  tlul_socket_1n_ordered #(
    .N              (N),
    .MaxOutstanding (MO)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .tl_h_i       (tl_h_i),
    .tl_h_o       (tl_h_o),
    .dev_select_i (dev_sel),
    .tl_d_o       (tl_d_o),
    .tl_d_i       (tl_d_i)
  );

  typedef struct packed {
    logic [2:0]  opcode;
    logic [2:0]  param;
    logic [1:0]  size;
    logic [7:0]  source;
    logic        sink;
    logic [31:0] data;
    logic        error;
  } rsp_t;

  typedef struct {
    rsp_t rsp;
    int   tgt;
  } exp_t;

  typedef struct {
    rsp_t        rsp;
    int unsigned due;
  } dev_ent_t;

  exp_t           sb[$];
  dev_ent_t       devq[N][$];
  bit             dev_pres[N];
  int unsigned    cyc = 0;
  int             checks = 0;
  int             errors = 0;
  int             stall = 0;
  bit             a_taken = 0;
  bit             did_rst = 0;
  logic [NWD-1:0] sel_v = '0;

  function automatic logic [31:0] dev_data(int j, logic [31:0] addr);
    return {4'(j), addr[27:0]} ^ 32'h5A5A_0000;
  endfunction

  // Response the socket must return for a request accepted towards target tgt
  function automatic rsp_t expect_rsp(int tgt, tl_h2d_t a);
    rsp_t r;
    logic is_get;
    is_get   = (a.a_opcode == Get);
    r.opcode = is_get ? 3'd1 : 3'd0;
    r.param  = 3'd0;
    r.size   = a.a_size;
    r.source = a.a_source;
    r.sink   = 1'b0;
    if (tgt >= int'(N)) begin
      r.data  = 32'hFFFF_FFFF;
      r.error = 1'b1;
    end else begin
      r.data  = is_get ? dev_data(tgt, a.a_address) : 32'h0;
      r.error = 1'b0;
    end
    return r;
  endfunction

  task automatic chk(string nm, int idx, logic got, logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s[%0d] cyc %0d: got %0b want %0b", nm, idx, cyc, got, exp);
    end
  endtask

  // mode 0: random traffic, 1: host idle (drain), 2: host idle, devices replay stale responses
  task automatic drive(int mode);
    cyc++;
    if (mode == 0) begin
      if (!tl_h_i.a_valid || a_taken) begin
        a_taken = 0;
        if ($urandom_range(0, 9) < 6) begin
          if ($urandom_range(0, 9) < 3) sel_v = NWD'($urandom_range(0, 5));
          dev_sel            = sel_v;
          tl_h_i.a_valid     = 1'b1;
          tl_h_i.a_opcode    = ($urandom_range(0, 1) != 0) ? Get : PutFullData;
          tl_h_i.a_param     = 3'd0;
          tl_h_i.a_size      = 2'($urandom_range(0, 2));
          tl_h_i.a_source    = 8'($urandom);
          tl_h_i.a_address   = $urandom;
          tl_h_i.a_mask      = '1;
          tl_h_i.a_data      = $urandom;
        end else begin
          tl_h_i.a_valid = 1'b0;
          dev_sel        = NWD'($urandom_range(0, 7));
        end
      end
      tl_h_i.d_ready = ($urandom_range(0, 9) < 8);
    end else begin
      tl_h_i.a_valid = 1'b0;
      a_taken        = 0;
      tl_h_i.d_ready = (mode == 2) ? 1'b1 : ($urandom_range(0, 9) < 8);
    end
    for (int j = 0; j < int'(N); j++) begin
      tl_d_i[j].a_ready = ($urandom_range(0, 3) != 0);
      if (!dev_pres[j] && devq[j].size() > 0 &&
          (mode == 2 || (cyc >= devq[j][0].due && $urandom_range(0, 3) != 0)))
        dev_pres[j] = 1;
      if (dev_pres[j]) begin
        tl_d_i[j].d_valid  = 1'b1;
        tl_d_i[j].d_opcode = tl_d_op_e'(devq[j][0].rsp.opcode);
        tl_d_i[j].d_param  = devq[j][0].rsp.param;
        tl_d_i[j].d_size   = devq[j][0].rsp.size;
        tl_d_i[j].d_source = devq[j][0].rsp.source;
        tl_d_i[j].d_sink   = devq[j][0].rsp.sink;
        tl_d_i[j].d_data   = devq[j][0].rsp.data;
        tl_d_i[j].d_error  = devq[j][0].rsp.error;
      end else begin
        tl_d_i[j].d_valid  = 1'b0;
        tl_d_i[j].d_opcode = AccessAckData;
        tl_d_i[j].d_source = 8'($urandom);
        tl_d_i[j].d_data   = $urandom;
        tl_d_i[j].d_error  = 1'b0;
      end
    end
  endtask

  // Combinational checks against the ordering rules, then bookkeeping of handshakes
  task automatic evaluate();
    int tm, ft;
    bit busy, err_busy, hold_m, exp_ar, exp_dv;
    exp_t e;
    dev_ent_t de;
    busy     = (sb.size() != 0);
    ft       = busy ? sb[0].tgt : -1;
    err_busy = 0;
    foreach (sb[k]) if (sb[k].tgt == int'(N)) err_busy = 1;
    tm     = (int'(dev_sel) < int'(N)) ? int'(dev_sel) : int'(N);
    hold_m = (busy && tm != ft) || (sb.size() == int'(MO));
    if (tm < int'(N)) exp_ar = !hold_m && tl_d_i[tm].a_ready;
    else              exp_ar = !hold_m && !err_busy;
    if (!busy)                 exp_dv = 0;
    else if (ft == int'(N))    exp_dv = 1;
    else                       exp_dv = tl_d_i[ft].d_valid;
    chk("a_ready", 0, tl_h_o.a_ready, exp_ar);
    chk("d_valid", 0, tl_h_o.d_valid, exp_dv);
    for (int j = 0; j < int'(N); j++) begin
      chk("dev_a_valid", j, tl_d_o[j].a_valid, tl_h_i.a_valid && tm == j && !hold_m);
      chk("dev_d_ready", j, tl_d_o[j].d_ready, tl_h_i.d_ready && busy && ft == j);
    end
    if (tl_h_i.a_valid && tl_h_o.a_ready) begin
      e.rsp = expect_rsp(tm, tl_h_i);
      e.tgt = tm;
      sb.push_back(e);
      a_taken = 1;
    end
    for (int j = 0; j < int'(N); j++) begin
      if (tl_d_o[j].a_valid && tl_d_i[j].a_ready) begin
        de.rsp = expect_rsp(j, tl_d_o[j]);
        de.due = cyc + $urandom_range(1, 8);
        devq[j].push_back(de);
      end
      if (tl_d_i[j].d_valid && tl_d_o[j].d_ready && devq[j].size() > 0) begin
        void'(devq[j].pop_front());
        dev_pres[j] = 0;
      end
    end
    if (busy && !(tl_h_o.d_valid && tl_h_i.d_ready)) stall++;
    else stall = 0;
    if (stall == 300) begin
      errors++;
      $display("FAIL stall cyc %0d: got no response for 300 cycles want progress", cyc);
    end
  endtask

  // Monitor: every host D handshake must match the oldest expected response
  initial begin
    rsp_t got;
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (!rst && tl_h_o.d_valid && tl_h_i.d_ready) begin
        got.opcode = tl_h_o.d_opcode;
        got.param  = tl_h_o.d_param;
        got.size   = tl_h_o.d_size;
        got.source = tl_h_o.d_source;
        got.sink   = tl_h_o.d_sink;
        got.data   = tl_h_o.d_data;
        got.error  = tl_h_o.d_error;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL rsp_unexpected cyc %0d: got %h want none", cyc, got);
        end else begin
          e = sb.pop_front();
          if (got !== e.rsp) begin
            errors++;
            $display("FAIL rsp_tgt%0d cyc %0d: got %h want %h", e.tgt, cyc, got, e.rsp);
          end
        end
      end
    end
  end

  task automatic mid_reset();
    @(posedge clk);
    #1;
    rst            = 1'b1;
    sb.delete();
    a_taken        = 0;
    tl_h_i.a_valid = 1'b0;
    tl_h_i.d_ready = 1'b1;
    #1;
    chk("rst_d_valid", 0, tl_h_o.d_valid, 1'b0);
    for (int j = 0; j < int'(N); j++) chk("rst_d_ready", j, tl_d_o[j].d_ready, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(2);
    @(negedge clk);
    evaluate();
    repeat (3) begin
      @(posedge clk);
      #1;
      drive(2);
      @(negedge clk);
      evaluate();
    end
    for (int j = 0; j < int'(N); j++) begin
      devq[j].delete();
      dev_pres[j] = 0;
    end
  endtask

  initial begin
    rst    = 1'b0;
    tl_h_i = '0;
    dev_sel = '0;
    for (int j = 0; j < int'(N); j++) begin
      tl_d_i[j]         = '0;
      tl_d_i[j].d_valid = 1'b1;
      tl_d_i[j].a_ready = 1'b1;
      dev_pres[j]       = 0;
    end
    #1 rst = 1'b1;
    tl_h_i.a_valid  = 1'b1;
    tl_h_i.d_ready  = 1'b1;
    tl_h_i.a_opcode = Get;
    dev_sel         = NWD'(2);
    @(negedge clk);
    chk("reset_d_valid", 0, tl_h_o.d_valid, 1'b0);
    for (int j = 0; j < int'(N); j++) begin
      chk("reset_d_ready", j, tl_d_o[j].d_ready, 1'b0);
      chk("reset_a_valid", j, tl_d_o[j].a_valid, j == 2);
    end
    tl_h_i.a_valid = 1'b0;
    for (int j = 0; j < int'(N); j++) tl_d_i[j].d_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;

    for (int c = 0; c < 3000; c++) begin
      if (!did_rst && c >= 1200 && sb.size() >= 2 && sb[0].tgt < int'(N)) begin
        did_rst = 1;
        mid_reset();
      end else if (!did_rst && c == 1800) begin
        did_rst = 1;
        errors++;
        $display("FAIL reset_setup cyc %0d: got outstanding %0d want >= 2", cyc, sb.size());
      end
      @(posedge clk);
      #1;
      drive(c < 2700 ? 0 : 1);
      @(negedge clk);
      evaluate();
    end

    for (int c = 0; c < 500 && sb.size() != 0; c++) begin
      @(posedge clk);
      #1;
      drive(1);
      @(negedge clk);
      evaluate();
    end
    @(negedge clk);
    #2;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d outstanding want 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tlul_socket_1n_ordered.md
# tlul_socket_1n_ordered

Single-host to N-device TL-UL steering socket: routes each A-channel request from one host port to the device selected by an external address decoder, and returns D-channel responses to the host strictly in request order. Sits between a crossbar host port and its device ports, the mirror of the M:1 host-merging socket. Out-of-range selects are absorbed by an internal error responder. Zero-latency A and D paths, no FIFOs.

## Interface
- N, 4: number of device ports; 1..15.
- MaxOutstanding, 8: maximum in-flight requests; 1..255.
- NWD, $clog2(N+1): width of device select (localparam-derived, not overridden).
- clk_i  in  1  clock.
- rst_i  in  1  reset; one clock; reset is asynchronous and active-high.
- tl_h_i  in  tlul_pkg::tl_h2d_t  host request / d_ready.
- tl_h_o  out  tlul_pkg::tl_d2h_t  host response / a_ready.
- dev_select_i  in  NWD  target for current tl_h_i request; values >= N mean "no device" and route to the error responder; stable while tl_h_i.a_valid=1.
- tl_d_o  out  tlul_pkg::tl_h2d_t [N]  device requests.
- tl_d_i  in  tlul_pkg::tl_d2h_t [N]  device responses.

## Operation
- State: out_cnt (width $clog2(MaxOutstanding+1)), cur_dev (NWD), error responder (err_pend, err_source, err_size, err_isget).
- Target index t = dev_select_i if < N, else N (error responder).
- hold = (out_cnt != 0 && t != cur_dev) || (out_cnt == MaxOutstanding).
- A path: tl_d_o[j] carries all tl_h_i A fields; tl_d_o[j].a_valid = tl_h_i.a_valid & (t==j) & !hold. tl_h_o.a_ready = !hold & (t<N ? tl_d_i[t].a_ready : !err_pend).
- A handshake = tl_h_i.a_valid & tl_h_o.a_ready; on it cur_dev <= t.
- D path: tl_h_o D fields taken from tl_d_i[cur_dev] (or error responder if cur_dev==N); tl_h_o.d_valid asserted only if out_cnt != 0. tl_d_o[j].d_ready = tl_h_i.d_ready & (j==cur_dev) & (out_cnt!=0); all other d_ready = 0.
- D handshake = tl_h_o.d_valid & tl_h_i.d_ready.
- out_cnt: +1 on A handshake only, -1 on D handshake only, unchanged on both/neither. Never wraps; hold guarantees no increment at MaxOutstanding.
- Error responder: accepts when !err_pend; captures a_source, a_size, opcode==Get. Next cycle d_valid=1, d_error=1, d_opcode=AccessAckData if Get else AccessAck, d_data='1, d_source/d_size captured, d_param/d_sink=0. Clears err_pend on its D handshake; single entry, so back-to-back errors accept every other cycle.
- Device responses arriving while cur_dev points elsewhere are stalled (d_ready=0); never dropped.

## Timing
- Reset: out_cnt=0, cur_dev=0, err_pend=0; tl_h_o.d_valid=0, all tl_d_o d_ready=0; tl_d_o a_valid follows host combinationally (0 if host idle).
- A and D paths combinational: 0-cycle added latency. Error response 1 cycle after acceptance.
- Simultaneous A and D handshake in same cycle with same target: allowed, out_cnt unchanged, cur_dev unchanged.
- Switching target: A stalls until out_cnt reaches 0; request accepted in the same cycle the last response handshakes only if out_cnt is 0 at cycle start (registered count; no same-cycle bypass).
- rst_i mid-transaction: all state cleared immediately; in-flight responses subsequently presented by devices are not forwarded (out_cnt=0).

## Test plan
- Single Get to dev 2, dev responds 3 cycles later with d_data=0xCAFE0001 -> host sees one d_valid with 0xCAFE0001, d_source echoed, out_cnt 0->1->0.
- 4 back-to-back Puts to dev 1, then Get to dev 0 -> Get a_ready=0 until all 4 dev-1 responses handshake, then accepted next cycle; response order 1,1,1,1,0.
- MaxOutstanding=2, 3 Gets to dev 0 with device withholding D -> third request stalls; releases one cycle after first D handshake.
- dev_select_i=N (out of range) Get, a_source=5, a_size=2 -> next cycle d_error=1, AccessAckData, d_data=0xFFFFFFFF, d_source=5; no tl_d_o a_valid asserted.
- Host d_ready=0 for 5 cycles on pending response -> device d_ready held 0, host d_valid held, no data change; then single handshake.
- Assert rst_i with out_cnt=3 -> all outputs return to reset values same cycle; later device d_valid not forwarded to host.
